// File: rtl/dp_ram_port_arbiter_if.sv
// One ibex-style req/gnt/rvalid bus.
// master drives requests; slave answers them.
interface dp_ram_port_arbiter_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dp_ram_port_arbiter.sv
// Two-master arbiter onto one dp_ram port:
// m0 priority, m1 starvation guard, rdata routing.
module dp_ram_port_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  dp_ram_port_arbiter_if.slave  m0,
  dp_ram_port_arbiter_if.slave  m1,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  typedef enum logic {
    PRIO_M0,
    PRIO_M1
  } prio_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic       r_ready;
  prio_e      r_prio;
  prio_e      w_prio_nxt;
  logic [7:0] r_starve_cnt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_cnt_inc;
  logic [1:0] r_rvalid;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_unused;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ready      <= 1'b0;
      r_prio       <= PRIO_M0;
      r_starve_cnt <= 8'd0;
      r_rvalid     <= 2'b00;
    end else begin
      r_ready      <= 1'b1;
      r_prio       <= w_prio_nxt;
      r_starve_cnt <= w_cnt_nxt;
      r_rvalid     <= {w_gnt1, w_gnt0};
    end
  end

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_ready) begin
      unique case (r_prio)
        PRIO_M0: begin
          w_gnt0 = m0.req;
          w_gnt1 = m1.req & ~m0.req;
        end
        PRIO_M1: begin
          w_gnt1 = m1.req;
          w_gnt0 = m0.req & ~m1.req;
        end
        default: ;
      endcase
    end
  end

  assign w_cnt_inc = r_starve_cnt + 8'd1;

  // m1 waiting under m0 priority accumulates; a grant or idle clears it
  always_comb begin
    w_prio_nxt = r_prio;
    w_cnt_nxt  = 8'd0;
    unique case (r_prio)
      PRIO_M0: begin
        if (m1.req & ~w_gnt1) begin
          if (w_cnt_inc == LIMIT) begin
            w_prio_nxt = PRIO_M1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      PRIO_M1: begin
        if (w_gnt1) begin
          w_prio_nxt = PRIO_M0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ram_en_o    = w_gnt0 | w_gnt1;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'b0000;
    ram_addr_o  = m0.addr[ADDR_WIDTH+1:2];
    ram_wdata_o = m0.wdata;
    unique case (1'b1)
      w_gnt0: begin
        ram_we_o = m0.we;
        ram_be_o = m0.be;
      end
      w_gnt1: begin
        ram_we_o    = m1.we;
        ram_be_o    = m1.be;
        ram_addr_o  = m1.addr[ADDR_WIDTH+1:2];
        ram_wdata_o = m1.wdata;
      end
      default: ;
    endcase
  end

  assign m0.gnt    = w_gnt0;
  assign m1.gnt    = w_gnt1;
  assign m0.rvalid = r_rvalid[0];
  assign m1.rvalid = r_rvalid[1];
  assign m0.rdata  = r_rvalid[0] ? ram_rdata_i : 32'd0;
  assign m1.rdata  = r_rvalid[1] ? ram_rdata_i : 32'd0;

  // aliased upper bits and byte offset are intentionally dropped
  assign w_unused = ^{m0.addr[31:ADDR_WIDTH+2], m0.addr[1:0],
                      m1.addr[31:ADDR_WIDTH+2], m1.addr[1:0]};

endmodule

// File: tb/tb_dp_ram_port_arbiter.sv
// Bench for dp_ram_port_arbiter: RAM model, cycle
// reference model, directed scenarios.
module tb_dp_ram_port_arbiter;
  localparam int AW = 12;
  localparam int LIM = 4;

  logic clk;
  logic rst_n;
  logic chk_on;
  int   n_chk;
  int   n_err;

  dp_ram_port_arbiter_if u_m0 ();
  dp_ram_port_arbiter_if u_m1 ();

  logic          ram_en;
  logic          ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  dp_ram_port_arbiter #(
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .m0         (u_m0),
    .m1         (u_m1),
    .ram_en_o   (ram_en),
    .ram_we_o   (ram_we),
    .ram_be_o   (ram_be),
    .ram_addr_o (ram_addr),
    .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(
    input logic [31:0] old, input logic [31:0] nw,
    input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // dp_ram port B: 1-cycle latency, write-first
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_be);
        ram_rdata     <= merge(mem[ram_addr], ram_wdata, ram_be);
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  // reference model: who wins, what the RAM should hold
  logic        mr_ready;
  logic        mr_boost;
  int          mr_wait;
  logic        mr_rv0;
  logic        mr_rv1;
  logic [31:0] mr_data;
  logic [31:0] shadow [0:4095];
  logic        eg0;
  logic        eg1;

  always_comb begin
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (mr_ready) begin
      if (mr_boost) begin
        eg1 = u_m1.req;
        eg0 = u_m0.req && !u_m1.req;
      end else begin
        eg0 = u_m0.req;
        eg1 = u_m1.req && !u_m0.req;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        we;
    int          w;
    if (!rst_n) begin
      mr_ready <= 1'b0;
      mr_boost <= 1'b0;
      mr_wait  <= 0;
      mr_rv0   <= 1'b0;
      mr_rv1   <= 1'b0;
      mr_data  <= 32'd0;
    end else begin
      mr_ready <= 1'b1;
      mr_rv0   <= eg0;
      mr_rv1   <= eg1;
      if (eg0 || eg1) begin
        a  = eg0 ? u_m0.addr  : u_m1.addr;
        d  = eg0 ? u_m0.wdata : u_m1.wdata;
        be = eg0 ? u_m0.be    : u_m1.be;
        we = eg0 ? u_m0.we    : u_m1.we;
        w  = int'(a[AW+1:2]);
        if (we) begin
          shadow[w] <= merge(shadow[w], d, be);
          mr_data   <= merge(shadow[w], d, be);
        end else begin
          mr_data <= shadow[w];
        end
      end
      if (!mr_boost) begin
        if (u_m1.req && !eg1) begin
          if (mr_wait + 1 >= LIM) begin
            mr_boost <= 1'b1;
            mr_wait  <= 0;
          end else begin
            mr_wait <= mr_wait + 1;
          end
        end else begin
          mr_wait <= 0;
        end
      end else if (eg1) begin
        mr_boost <= 1'b0;
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("gnt0", 32'(u_m0.gnt), 32'(eg0));
      chk("gnt1", 32'(u_m1.gnt), 32'(eg1));
      chk("ram_en", 32'(ram_en), 32'(eg0 | eg1));
      if (eg0 || eg1) begin
        chk("ram_we", 32'(ram_we), 32'(eg0 ? u_m0.we : u_m1.we));
        chk("ram_be", 32'(ram_be), 32'(eg0 ? u_m0.be : u_m1.be));
        chk("ram_addr", 32'(ram_addr),
            32'(eg0 ? u_m0.addr[AW+1:2] : u_m1.addr[AW+1:2]));
        chk("ram_wdata", ram_wdata, eg0 ? u_m0.wdata : u_m1.wdata);
      end else begin
        chk("ram_we_idle", 32'(ram_we), 32'd0);
        chk("ram_be_idle", 32'(ram_be), 32'd0);
      end
      chk("rvalid0", 32'(u_m0.rvalid), 32'(mr_rv0));
      chk("rvalid1", 32'(u_m1.rvalid), 32'(mr_rv1));
      chk("rdata0", u_m0.rdata, mr_rv0 ? mr_data : 32'd0);
      chk("rdata1", u_m1.rdata, mr_rv1 ? mr_data : 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic set0(input logic r, input logic w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d);
    u_m0.req = r; u_m0.we = w; u_m0.be = b;
    u_m0.addr = a; u_m0.wdata = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d);
    u_m1.req = r; u_m1.we = w; u_m1.be = b;
    u_m1.addr = a; u_m1.wdata = d;
  endtask

  task automatic idle();
    u_m0.req = 1'b0;
    u_m1.req = 1'b0;
  endtask

  logic [11:0] seq;

  initial begin
    n_chk  = 0;
    n_err  = 0;
    chk_on = 1'b0;
    rst_n  = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = 32'h1000_0000 + 32'(i);
      shadow[i] = 32'h1000_0000 + 32'(i);
    end
    ram_rdata = 32'd0;
    set0(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    set1(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    #7 chk_on = 1'b1;
    sample();
    chk("rst_gnt0", 32'(u_m0.gnt), 32'd0);
    chk("rst_rvalid0", 32'(u_m0.rvalid), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    #1 rst_n = 1'b1;
    step();

    // T1 m0 read 0x10
    set0(1'b1, 1'b0, 4'h0, 32'h10, 32'd0);
    sample();
    chk("t1_gnt0", 32'(u_m0.gnt), 32'd1);
    chk("t1_addr", 32'(ram_addr), 32'd4);
    chk("t1_we", 32'(ram_we), 32'd0);
    step();
    idle();
    sample();
    chk("t1_rvalid0", 32'(u_m0.rvalid), 32'd1);
    chk("t1_rdata0", u_m0.rdata, 32'h1000_0004);
    chk("t1_rvalid1", 32'(u_m1.rvalid), 32'd0);
    // aliased m1 read, checked by the model
    set1(1'b1, 1'b0, 4'h0, 32'h1234_5013, 32'd0);
    step();
    idle();
    step();

    // T2 m1 partial write, then readback
    set1(1'b1, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD);
    sample();
    chk("t2_we", 32'(ram_we), 32'd1);
    chk("t2_be", 32'(ram_be), 32'h5);
    chk("t2_addr", 32'(ram_addr), 32'd8);
    step();
    idle();
    sample();
    chk("t2_rvalid1", 32'(u_m1.rvalid), 32'd1);
    set0(1'b1, 1'b0, 4'h0, 32'h20, 32'd0);
    step();
    idle();
    sample();
    chk("t2_readback", u_m0.rdata, 32'h10BB_00DD);
    step();

    // T3 both requesting for 12 cycles
    set0(1'b1, 1'b0, 4'h0, 32'h0, 32'd0);
    set1(1'b1, 1'b0, 4'h0, 32'h4, 32'd0);
    seq = '0;
    for (int i = 0; i < 12; i++) begin
      sample();
      seq = {seq[10:0], u_m1.gnt};
      step();
    end
    idle();
    chk("t3_seq", 32'(seq), 32'h084);
    step();

    // T4 reach m1 priority, m1 goes idle, then returns
    set0(1'b1, 1'b0, 4'h0, 32'h8, 32'd0);
    set1(1'b1, 1'b0, 4'h0, 32'hC, 32'd0);
    repeat (4) step();
    u_m1.req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("t4_m0_served", 32'(u_m0.gnt), 32'd1);
      step();
    end
    u_m1.req = 1'b1;
    sample();
    chk("t4_m1_wins", 32'(u_m1.gnt), 32'd1);
    chk("t4_m0_waits", 32'(u_m0.gnt), 32'd0);
    step();
    sample();
    chk("t4_back_m0", 32'(u_m0.gnt), 32'd1);
    idle();
    step();

    // T5 reset right after an m0 grant
    set0(1'b1, 1'b0, 4'h0, 32'h10, 32'd0);
    sample();
    chk("t5_gnt0", 32'(u_m0.gnt), 32'd1);
    #1 rst_n = 1'b0;
    step();
    chk("t5_no_rvalid", 32'(u_m0.rvalid), 32'd0);
    #2 rst_n = 1'b1;
    sample();
    chk("t5_not_ready", 32'(u_m0.gnt), 32'd0);
    step();
    sample();
    chk("t5_regrant", 32'(u_m0.gnt), 32'd1);
    step();
    idle();
    sample();
    chk("t5_rdata", u_m0.rdata, 32'h1000_0004);
    step();

    // T6 back-to-back read/write/read on one word
    set0(1'b1, 1'b0, 4'h0, 32'h40, 32'd0);
    sample();
    chk("t6_gnt_rd1", 32'(u_m0.gnt), 32'd1);
    step();
    set0(1'b1, 1'b1, 4'hF, 32'h40, 32'hCAFE_F00D);
    sample();
    chk("t6_gnt_wr", 32'(u_m0.gnt), 32'd1);
    chk("t6_rd1_data", u_m0.rdata, 32'h1000_0010);
    step();
    set0(1'b1, 1'b0, 4'h0, 32'h40, 32'd0);
    sample();
    chk("t6_gnt_rd2", 32'(u_m0.gnt), 32'd1);
    step();
    idle();
    sample();
    chk("t6_rd2_data", u_m0.rdata, 32'hCAFE_F00D);
    repeat (2) step();

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
